// File: rtl/serial_loader.sv
// Framed serial receiver: start bit, WIDTH data bits LSB first, stop bit.
// Good frames are presented on data_out with a one-cycle load pulse; bad stop bits set frame_err.
module serial_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load_q, load_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    err_d   = err_q;
    load_d  = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = serial_in;
          // Counter parks at WIDTH-1 on the last bit instead of wrapping.
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          state_d = IDLE;
          if (serial_in) begin
            data_d = shift_q;
            load_d = 1'b1;
            err_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign load      = load_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: expected words are queued when a good frame is sent
// and compared by a monitor whenever load pulses.
module tb_serial_loader;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             bit_en = 1'b0;
  logic             serial_in = 1'b1;
  logic [WIDTH-1:0] data_out;
  logic             load;
  logic             frame_err;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int loads_seen = 0;
  logic prev_load = 1'b0;
  logic [WIDTH-1:0] exp_q[$];
  int load_cycles[$];

  serial_loader #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bit_en(bit_en),
    .serial_in(serial_in),
    .data_out(data_out),
    .load(load),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every load pulse must match the oldest queued good frame.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      logic [WIDTH-1:0] exp_w;
      loads_seen++;
      load_cycles.push_back(cyc);
      check("load_without_frame", 32'(exp_q.size() != 0), 32'd1);
      exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("load_data_out", 32'(data_out), 32'(exp_w));
      check("load_frame_err", 32'(frame_err), 32'd0);
      check("load_not_consecutive", 32'(prev_load), 32'd0);
      $display("load: data_out=%02h at cycle %0d", data_out, cyc);
    end
    prev_load = load;
  end

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic strobe(input logic b);
    serial_in = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop, input int gap);
    strobe(1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    repeat (gap - 1) @(negedge clk);
    for (int i = 0; i < WIDTH; i++) begin
      strobe(w[i]);
      check("busy_in_data", 32'(busy), 32'd1);
      repeat (gap - 1) @(negedge clk);
    end
    if (stop) exp_q.push_back(w);
    strobe(stop);
    check("busy_after_stop", 32'(busy), 32'd0);
    check("load_after_stop", 32'(load), 32'(stop));
    check("frame_err_after_stop", 32'(frame_err), 32'(!stop));
    $display("frame sent: word=%02h stop=%0b", w, stop);
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    int n0;
    int loads_before;
    logic [WIDTH-1:0] hold;

    // Asynchronous reset with no clock edge in between.
    #1 rst = 1'b1;
    #1;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_load", 32'(load), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Good frame, bit_en every 4th cycle.
    send_frame(8'hA5, 1'b1, 4);
    repeat (6) @(negedge clk);
    check("a5_hold", 32'(data_out), 32'hA5);
    check("a5_one_load", 32'(loads_seen), 32'd1);

    // Bad stop bit leaves data_out alone, then a good retry.
    send_frame(8'h3C, 1'b0, 4);
    check("bad_data_hold", 32'(data_out), 32'hA5);
    check("bad_no_load", 32'(loads_seen), 32'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(frame_err), 32'd1);
    send_frame(8'h3C, 1'b1, 4);
    check("retry_data", 32'(data_out), 32'h3C);

    // Back-to-back with bit_en held high.
    n0 = load_cycles.size();
    send_frame(8'hFF, 1'b1, 1);
    send_frame(8'h00, 1'b1, 1);
    @(negedge clk);
    check("b2b_two_loads", 32'(load_cycles.size() - n0), 32'd2);
    if (load_cycles.size() >= n0 + 2)
      check("b2b_spacing", 32'(load_cycles[n0+1] - load_cycles[n0]), 32'd10);
    check("b2b_last_data", 32'(data_out), 32'h00);

    // Reset mid-frame discards the partial word.
    loads_before = loads_seen;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'(i & 1));
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    check("mid_no_load", 32'(loads_seen), 32'(loads_before));
    @(negedge clk);
    send_frame(8'h5A, 1'b1, 2);
    check("mid_one_load", 32'(loads_seen), 32'(loads_before + 1));
    check("mid_data", 32'(data_out), 32'h5A);

    // Idle noise: lows without bit_en, then strobes with the line high.
    hold = data_out;
    loads_before = loads_seen;
    for (int i = 0; i < 6; i++) begin
      serial_in = 1'(i & 1);
      @(negedge clk);
      check("noise_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1);
      check("noise_strobe_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    check("noise_data", 32'(data_out), 32'(hold));
    check("noise_err", 32'(frame_err), 32'd0);
    check("noise_no_load", 32'(loads_seen), 32'(loads_before));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
